// File: rtl/uart_pkg.sv
// Shared definitions for the lab UART: state encoding, baud codes and the
// baud-code to tick-divisor table.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int FRAME_BITS = 11;

  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

  typedef enum logic [2:0] {
    ST_DISABLED  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START_BIT = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5
  } tx_state_t;

  function automatic int baud_rate(input logic [2:0] code);
    case (code)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // Rounded divisor: clocks per oversample tick.
  function automatic logic [14:0] baud_divisor(input int clk_freq, input logic [2:0] code);
    int rate;
    rate = baud_rate(code);
    return 15'((clk_freq + 8 * rate) / (16 * rate));
  endfunction

endpackage

// File: rtl/baud_controller_t.sv
// Free-running 16x oversample tick generator for the transmit path; the
// restart input re-phases the divider so a frame starts on a clean bit edge.
module baud_controller_t #(
  parameter int CLK_FREQ = 100000000
) (
  input  logic       reset,
  input  logic       clk,
  input  logic [2:0] baud_select,
  input  logic       restart,
  output logic       sample_ENABLE
);
  import uart_pkg::*;

  logic [14:0] divisor;
  logic [14:0] div_cnt_reg;

  assign divisor       = baud_divisor(CLK_FREQ, baud_select);
  assign sample_ENABLE = (div_cnt_reg == divisor - 15'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_reg <= '0;
    end else if (restart || sample_ENABLE) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 15'd1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, even parity, stop.
// Define UART_TX_HOLD_EN to add a one-deep holding register for back-to-back frames.
module uart_transmitter #(
  parameter int CLK_FREQ   = 100000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);
  import uart_pkg::*;

  tx_state_t  state_reg, state_next;
  logic [3:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] data_reg, data_next;
  logic       parity_reg, parity_next;
  logic [2:0] baud_reg, baud_next;
  logic       txd_reg, txd_next;
  logic       restart, sample_enable, bit_done, in_flight;

`ifdef UART_TX_HOLD_EN
  logic       hold_full_reg, hold_full_next;
  logic [7:0] hold_data_reg, hold_data_next;
  logic [2:0] hold_baud_reg, hold_baud_next;
`endif

  baud_controller_t #(.CLK_FREQ(CLK_FREQ)) u_baud (
    .reset        (reset),
    .clk          (clk),
    .baud_select  (baud_reg),
    .restart      (restart),
    .sample_ENABLE(sample_enable)
  );

  assign in_flight = (state_reg == ST_START_BIT) || (state_reg == ST_DATA) ||
                     (state_reg == ST_PARITY)    || (state_reg == ST_STOP);
  assign bit_done  = sample_enable && (tick_cnt_reg == 4'(OVERSAMPLE - 1));
  assign TxD       = txd_reg;

`ifdef UART_TX_HOLD_EN
  assign Tx_BUSY = in_flight | hold_full_reg;
`else
  assign Tx_BUSY = in_flight;
`endif

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    data_next     = data_reg;
    parity_next   = parity_reg;
    baud_next     = baud_reg;
    restart       = 1'b0;
    txd_next      = 1'b1;
`ifdef UART_TX_HOLD_EN
    hold_full_next = hold_full_reg;
    hold_data_next = hold_data_reg;
    hold_baud_next = hold_baud_reg;
`endif

    if (sample_enable) begin
      tick_cnt_next = tick_cnt_reg + 4'd1;
    end

    case (state_reg)
      ST_DISABLED: begin
        if (Tx_EN) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!Tx_EN) begin
          state_next = ST_DISABLED;
        end else if (Tx_WR) begin
          state_next    = ST_START_BIT;
          data_next     = Tx_DATA;
          parity_next   = ^Tx_DATA;
          baud_next     = baud_select;
          tick_cnt_next = '0;
          bit_idx_next  = '0;
          restart       = 1'b1;
        end
      end
      ST_START_BIT: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_reg == 3'd7) state_next = ST_PARITY;
          else bit_idx_next = bit_idx_reg + 3'd1;
        end
      end
      ST_PARITY: begin
        if (bit_done) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          state_next = Tx_EN ? ST_IDLE : ST_DISABLED;
`ifdef UART_TX_HOLD_EN
          // A held word goes straight into its start bit, no idle gap.
          if (hold_full_reg) begin
            state_next     = ST_START_BIT;
            data_next      = hold_data_reg;
            parity_next    = ^hold_data_reg;
            baud_next      = hold_baud_reg;
            tick_cnt_next  = '0;
            bit_idx_next   = '0;
            restart        = 1'b1;
            hold_full_next = 1'b0;
          end
`endif
        end
      end
      default: state_next = ST_DISABLED;
    endcase

`ifdef UART_TX_HOLD_EN
    if (in_flight && !(state_reg == ST_STOP && bit_done) && Tx_WR && Tx_EN && !hold_full_reg) begin
      hold_full_next = 1'b1;
      hold_data_next = Tx_DATA;
      hold_baud_next = baud_select;
    end
`endif

    // Output level is computed from the next state so TxD stays a flop.
    case (state_next)
      ST_START_BIT: txd_next = 1'b0;
      ST_DATA:      txd_next = data_next[bit_idx_next];
      ST_PARITY:    txd_next = parity_next;
      default:      txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_DISABLED;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      data_reg     <= '0;
      parity_reg   <= 1'b0;
      baud_reg     <= '0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      data_reg     <= data_next;
      parity_reg   <= parity_next;
      baud_reg     <= baud_next;
      txd_reg      <= txd_next;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
      hold_baud_reg <= '0;
    end else begin
      hold_full_reg <= hold_full_next;
      hold_data_reg <= hold_data_next;
      hold_baud_reg <= hold_baud_next;
    end
  end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frames are compared cycle by cycle
// against bit levels derived from the frame format and the rounded baud divisor.
module tb_uart_transmitter;

  localparam int CLK_FREQ = 7_372_800;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'd0;
  logic       Tx_EN = 1'b0;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       TxD;
  logic       Tx_BUSY;

  int tests_run = 0;
  int tests_failed = 0;

  uart_transmitter #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .Tx_EN      (Tx_EN),
    .Tx_WR      (Tx_WR),
    .Tx_DATA    (Tx_DATA),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Clocks per bit: 16 ticks of round(CLK_FREQ / (16 * baud)).
  function automatic int bit_period(input logic [2:0] b);
    real rate;
    case (b)
      3'd0: rate = 300.0;
      3'd1: rate = 1200.0;
      3'd2: rate = 4800.0;
      3'd3: rate = 9600.0;
      3'd4: rate = 19200.0;
      3'd5: rate = 38400.0;
      3'd6: rate = 57600.0;
      default: rate = 115200.0;
    endcase
    return 16 * $rtoi(real'(CLK_FREQ) / (16.0 * rate) + 0.5);
  endfunction

  // Watches the line for a while; any low TxD or high Tx_BUSY is activity.
  task automatic expect_quiet(input int cycles, input string tag);
    int active;
    active = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) active++;
    end
    check(tag, active, 0);
    $display("[TB] quiet %s cycles=%0d active=%0d", tag, cycles, active);
  endtask

  task automatic pulse_write(input logic [7:0] d);
    @(negedge clk);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR   = 1'b0;
  endtask

  // Sends one word and checks every cycle of the frame. Optional events at
  // frame-relative cycle k: a second write, Tx_EN drop, or a reset abort.
  task automatic run_frame(input logic [7:0] d, input logic [2:0] b, input int wr_at,
                           input logic [7:0] wr_d, input int en_drop_at, input int rst_at,
                           input string name);
    int   bp, n, bit_err, busy_err;
    logic exp_bits[11];
    logic aborted;
    bp = bit_period(b);
    n  = 11 * bp;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
    exp_bits[9]  = ^d;
    exp_bits[10] = 1'b1;
    bit_err  = 0;
    busy_err = 0;
    aborted  = 1'b0;

    @(negedge clk);
    Tx_DATA     = d;
    baud_select = b;
    Tx_WR       = 1'b1;
    @(negedge clk);
    Tx_WR       = 1'b0;
    baud_select = 3'($urandom_range(0, 7));

    for (int k = 0; k < n; k++) begin
      if (k == rst_at) begin
        #2 reset = 1'b1;
        Tx_EN = 1'b0;
        #1;
        check({name, "_rst_txd"}, TxD, 1);
        check({name, "_rst_busy"}, Tx_BUSY, 0);
        @(negedge clk);
        reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (TxD !== exp_bits[k / bp]) bit_err++;
      if (Tx_BUSY !== 1'b1) busy_err++;
      if (k == wr_at) begin
        Tx_DATA = wr_d;
        Tx_WR   = 1'b1;
      end else begin
        Tx_WR   = 1'b0;
      end
      if (k == en_drop_at) Tx_EN = 1'b0;
      @(negedge clk);
    end
    Tx_WR = 1'b0;

    if (!aborted) begin
      check({name, "_bits"}, bit_err, 0);
      check({name, "_busy"}, busy_err, 0);
      check({name, "_end_txd"}, TxD, 1);
      check({name, "_end_busy"}, Tx_BUSY, 0);
    end
    $display("[TB] frame %s data=%02h baud=%0d bit_clk=%0d bit_err=%0d busy_err=%0d aborted=%0d",
             name, d, b, bp, bit_err, busy_err, aborted);
  endtask

  initial begin
    logic [7:0] rd;
    logic [2:0] rb;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", TxD, 1);
    check("reset_busy", Tx_BUSY, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_txd", TxD, 1);

    pulse_write(8'h55);
    expect_quiet(300, "disabled_wr");

    Tx_EN = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(8'hA5, 3'd7, -1, 8'h00, -1, -1, "a5_b7");
    run_frame(8'h01, 3'd3, -1, 8'h00, -1, -1, "01_b3");
    run_frame(8'h00, 3'd6, -1, 8'h00, -1, -1, "00_b6");

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom);
      rb = 3'($urandom_range(4, 7));
      run_frame(rd, rb, -1, 8'h00, -1, -1, $sformatf("rand%0d", i));
    end

    // Write while busy mid-DATA: must not disturb this frame or start another.
    run_frame(8'hFF, 3'd7, 3 * bit_period(3'd7) + 10, 8'h3C, -1, -1, "busy_wr");
    expect_quiet(3 * bit_period(3'd7), "no_second_frame");

    // Tx_EN dropped in PARITY: frame completes, then writes are refused.
    run_frame(8'h96, 3'd7, -1, 8'h00, 9 * bit_period(3'd7) + bit_period(3'd7) / 2, -1, "en_drop");
    pulse_write(8'h42);
    expect_quiet(300, "en_off_wr");
    Tx_EN = 1'b1;
    repeat (2) @(negedge clk);

    // Reset during data bit 3, then stays disabled until Tx_EN returns.
    run_frame(8'hC3, 3'd6, -1, 8'h00, -1, 4 * bit_period(3'd6) + bit_period(3'd6) / 2, "rst_mid");
    pulse_write(8'h81);
    expect_quiet(300, "rst_disabled");
    Tx_EN = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'h5A, 3'd7, -1, 8'h00, -1, -1, "recover");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmitter: takes one 8-bit word per write strobe and shifts out an 11-bit frame on TxD. Frame format: start (0), 8 data bits LSB first, even parity, stop (1). Peer block of the lab UART receiver; shares baud_select encoding and frame format so TxD can be looped straight into RxD. Bit timing is derived from a 16x oversample tick, identical to the receive path.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz; used to compute baud divisors.
OVERSAMPLE, 16, oversample ticks per bit; fixed at 16 for receiver compatibility.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
baud_select  in  3  baud rate code; latched at frame accept
Tx_EN  in  1  transmitter enable
Tx_WR  in  1  single-cycle write strobe
Tx_DATA  in  8  word to transmit; sampled on the cycle Tx_WR is accepted
TxD  out  1  serial output, registered, idles high
Tx_BUSY  out  1  high while a frame is in flight (or the holding register is full, see Optional Feature)

Behaviour:
- Reset (async): TxD=1, Tx_BUSY=0, state DISABLED, tick and bit counters 0, data/parity registers 0.
- baud_select codes: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- Tick divisor = round(CLK_FREQ/(16*baud)). At 100 MHz: 20833, 5208, 1302, 651, 326, 163, 109, 54. Divider counter is 15 bits wide. Tick is a 1-clk pulse.
- Bit period is 16 ticks. At 115200 baud and 100 MHz: 864 clk per bit, 9504 clk per frame.
- States: DISABLED, IDLE, START_BIT, DATA, PARITY, STOP.
  - DISABLED: TxD=1. Goes to IDLE when Tx_EN=1.
  - IDLE: TxD=1. If Tx_EN=0, goes to DISABLED. If Tx_WR=1 and Tx_EN=1, accepts the word:
    - latches Tx_DATA and baud_select
    - computes parity = ^Tx_DATA
    - clears the divider and tick counters
    - goes to START_BIT on the next clk
  - START_BIT: TxD=0 for 16 ticks, then DATA.
  - DATA: TxD=data[bit_idx] with bit_idx 0..7, each held 16 ticks. After bit 7, goes to PARITY.
  - PARITY: TxD=parity for 16 ticks, then STOP.
  - STOP: TxD=1 for 16 ticks. Then IDLE, or DISABLED if Tx_EN=0.
- TxD is a registered output. First start-bit level appears 1 clk after the accept edge.
- Tx_BUSY: 1 from the clk after accept until the cycle STOP completes. It returns to 0 in the same cycle the state returns to IDLE.
- Tx_WR while busy: ignored, with no effect on the frame in flight (unless the Optional Feature is compiled in).
- Tx_EN deasserted mid-frame: the frame completes intact, then the block goes to DISABLED. New writes are refused while Tx_EN=0.
- baud_select changes mid-frame have no effect until the next accept.
- Reset mid-frame: the frame is aborted immediately and TxD=1 asynchronously.
- Tx_WR in the exact cycle STOP completes: ignored (accept only happens from IDLE).

Optional Feature:
Macro: UART_TX_HOLD_EN.
- With the macro: adds a one-deep holding register.
  - Tx_WR with Tx_EN=1 while a frame is in flight and the holding register is empty stores the word.
  - When STOP completes, the held word starts immediately: next clk is START_BIT, with no IDLE bit time in between.
  - Tx_BUSY = frame in flight OR holding register full.
  - A write while the holding register is full is dropped.
  - Reset clears the holding register.
- Without the macro: no holding register; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants
  - baud code constants
  - divisor table function (CLK_FREQ, baud_select → divisor)
  - OVERSAMPLE constant
  - frame length constant (11)
- Sub-module baud_controller_t: (reset, clk, baud_select, sample_ENABLE). Free-running 16x tick generator that clears on a sync restart input. Mirrors the receive-side baud controller.

Test Plan:
- Reset mid-frame: assert reset during DATA bit 3 → TxD=1 and Tx_BUSY=0 immediately; after release, the block stays DISABLED until Tx_EN=1.
- 0xA5 at baud 111, 100 MHz: Tx_EN=1, Tx_WR pulse → TxD sequence 0,1,0,1,0,0,1,0,1,0(parity),1. Each level lasts 864 clk; Tx_BUSY high for 9504 clk.
- 0x01 at baud 011: parity bit=1. Each bit lasts 10416 clk. Loopback into the receiver gives Rx_DATA=0x01, Rx_VALID=1, no errors.
- Tx_WR=0x3C issued while a 0xFF frame is mid-DATA → without the macro, only 0xFF is sent. With UART_TX_HOLD_EN, 0x3C starts on the clk after the 0xFF stop bit ends, and a third write during that window is dropped.
- Tx_EN dropped during PARITY → frame finishes with stop bit, state goes to DISABLED, and a subsequent Tx_WR produces no activity on TxD.
